// File: rtl/case_6_acc_26s_16_frame.sv
// Frame accumulator: sums FRAME_LEN signed products, then presents a rounded,
// right-shifted, saturated result through a valid/ready handshake.
module case_6_acc_26s_16_frame #(
  parameter int unsigned din_WIDTH  = 26,
  parameter int unsigned acc_WIDTH  = 40,
  parameter int unsigned dout_WIDTH = 16,
  parameter int unsigned FRAME_LEN  = 16,
  parameter int unsigned SHIFT      = 8
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         flush,
  input  logic signed [din_WIDTH-1:0]  in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [dout_WIDTH-1:0] out_data,
  output logic                         out_sat,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int unsigned CNT_W  = $clog2(FRAME_LEN);
  // Headroom for FRAME_LEN full-scale products plus the rounding bias
  localparam int unsigned NEED_W = din_WIDTH + CNT_W + 2;
  localparam int unsigned ACC_W  = (acc_WIDTH > NEED_W) ? acc_WIDTH : NEED_W;

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] MAXV =
    {{(ACC_W - dout_WIDTH + 1){1'b0}}, {(dout_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV =
    {{(ACC_W - dout_WIDTH + 1){1'b1}}, {(dout_WIDTH - 1){1'b0}}};

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_e;

  state_e                       state_q, state_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic signed [dout_WIDTH-1:0] out_data_q, out_data_d;
  logic                         out_sat_q, out_sat_d;

  logic signed [ACC_W-1:0]      sum_c;
  logic signed [ACC_W-1:0]      biased_c;
  logic signed [ACC_W-1:0]      rnd_c;
  logic signed [dout_WIDTH-1:0] res_data_c;
  logic                         res_sat_c;
  logic                         last_c;

  // Running sum including the current sample, rounded and clamped
  always_comb begin
    sum_c      = acc_q + ACC_W'(in_data);
    biased_c   = sum_c + HALF;
    rnd_c      = biased_c >>> SHIFT;
    res_data_c = rnd_c[dout_WIDTH-1:0];
    res_sat_c  = 1'b0;
    if (rnd_c > MAXV) begin
      res_data_c = MAXV[dout_WIDTH-1:0];
      res_sat_c  = 1'b1;
    end else if (rnd_c < MINV) begin
      res_data_c = MINV[dout_WIDTH-1:0];
      res_sat_c  = 1'b1;
    end
  end

  assign last_c = (cnt_q == CNT_W'(FRAME_LEN - 1));

  // Next-state logic; flush overrides any handshake in the same cycle
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    if (flush) begin
      state_d = S_ACC;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_ACC: begin
          if (in_valid) begin
            if (last_c) begin
              state_d    = S_OUT;
              acc_d      = '0;
              cnt_d      = '0;
              out_data_d = res_data_c;
              out_sat_d  = res_sat_c;
            end else begin
              acc_d = sum_c;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state_d = S_ACC;
          end
        end
        default: state_d = S_ACC;
      endcase
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q    <= S_ACC;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule
